// File: rtl/bm_decode_accum_if.sv
// rtl/bm_decode_accum_if.sv - job control, input beat and output chunk signals of the bitmatrix decoder
interface bm_decode_accum_if #(
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2
);
  logic                               start;
  logic [7:0]                         cfg_k;
  logic                               in_valid;
  logic                               in_ready;
  logic [W-1:0][W-1:0]                in_bitmatrix_cols;
  logic [W-1:0][PACKET_LENGTH-1:0]    in_data_packet;
  logic                               out_valid;
  logic                               out_ready;
  logic [W-1:0][PACKET_LENGTH-1:0]    out_data_packet;
  logic                               busy;
  logic                               cfg_err;

  modport master (
    output start, cfg_k, in_valid, in_bitmatrix_cols, in_data_packet, out_ready,
    input  in_ready, out_valid, out_data_packet, busy, cfg_err
  );

  modport slave (
    input  start, cfg_k, in_valid, in_bitmatrix_cols, in_data_packet, out_ready,
    output in_ready, out_valid, out_data_packet, busy, cfg_err
  );
endinterface

// File: rtl/bm_decode_accum.sv
// rtl/bm_decode_accum.sv - GF(2) bitmatrix decode: XOR-accumulates k matrix-weighted chunks into one output chunk
module bm_decode_accum #(
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int K_MIN         = 2,
  parameter int K_MAX         = 128
) (
  input  logic              clk,
  input  logic              rst,
  bm_decode_accum_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  localparam logic [7:0] K_MIN_B = 8'(K_MIN);
  localparam logic [7:0] K_MAX_B = 8'(K_MAX);

  state_t                          state_q, state_d;
  logic [W-1:0][PACKET_LENGTH-1:0] acc_q;
  logic [W-1:0][PACKET_LENGTH-1:0] product;
  logic [7:0]                      cnt_q;
  logic [7:0]                      k_q;
  logic                            cfg_err_q;
  logic                            cfg_ok;
  logic                            start_ok;
  logic                            start_bad;
  logic                            beat_acc;
  logic                            in_ready;
  logic                            out_valid;

  assign cfg_ok = (bus.cfg_k >= K_MIN_B) && (bus.cfg_k <= K_MAX_B);

  // Row r collects every input packet whose column has bit r set.
  always_comb begin
    product = '0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        if (bus.in_bitmatrix_cols[c][r]) begin
          product[r] = product[r] ^ bus.in_data_packet[c];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    beat_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            start_ok = 1'b1;
            state_d  = ACCUM;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          beat_acc = 1'b1;
          if (cnt_q == k_q - 8'd1) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= 8'd0;
      k_q       <= 8'd0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= start_bad;
      if (start_ok) begin
        k_q   <= bus.cfg_k;
        acc_q <= '0;
        cnt_q <= 8'd0;
      end else if (beat_acc) begin
        acc_q <= acc_q ^ product;
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid;
  assign bus.out_data_packet = out_valid ? acc_q : '0;
  assign bus.busy            = (state_q != IDLE);
  assign bus.cfg_err         = cfg_err_q;

endmodule
